// File: rtl/pow2_rate_sequencer_pkg.sv
// rate_seq_pkg: shared types and helpers for the power-of-two rate sequencer.
package rate_seq_pkg;

    localparam int POW_W = 3;

    typedef logic [POW_W-1:0] power_t;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    function automatic logic [7:0] pow_mask(input power_t p);
        return (8'd1 << p) - 8'd1;
    endfunction

endpackage

// File: rtl/pow2_rate_sequencer_tick.sv
// pow2_tick_gen: free-running divider that strobes Tick once every 2^Power enabled cycles.
module pow2_tick_gen
    import rate_seq_pkg::*;
(
    input  logic         Clock,
    input  logic         Clear,
    input  logic         Enable,
    input  power_t       Power,
    output logic         Tick
);

    logic [7:0] cnt;
    logic [7:0] mask;

    assign mask = pow_mask(Power);
    assign Tick = Enable && (cnt == mask);

    always_ff @(posedge Clock) begin
        if (Clear)
            cnt <= '0;
        else if (Enable)
            cnt <= (cnt == mask) ? 8'd0 : cnt + 8'd1;
    end

endmodule

// File: rtl/pow2_rate_sequencer.sv
// pow2_rate_sequencer: steps a tick generator through a table of (power, count) entries.
// Optional TickTotal output counter enabled by defining RATE_SEQ_TICK_COUNT_EN.
module pow2_rate_sequencer
    import rate_seq_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     Clock,
    input  logic                     Reset,
    input  logic                     Start,
    input  logic                     Stop,
    input  logic                     Loop,
    input  logic                     WrEn,
    input  logic [$clog2(DEPTH)-1:0] WrAddr,
    input  logic [POW_W-1:0]         WrPower,
    input  logic [CNT_W-1:0]         WrCount,
    output logic                     Busy,
    output logic                     Tick,
    output logic                     Done,
    output logic [$clog2(DEPTH)-1:0] CurIndex,
    output logic [POW_W-1:0]         CurPower
`ifdef RATE_SEQ_TICK_COUNT_EN
    ,
    output logic [15:0]              TickTotal
`endif
);

    localparam int IW = $clog2(DEPTH);

    typedef struct packed {
        power_t           power;
        logic [CNT_W-1:0] count;
    } entry_t;

    entry_t           tbl [DEPTH];
    state_t           state, state_n;
    logic [IW-1:0]    idx, idx_n, idx_inc;
    logic [CNT_W-1:0] remaining;
    logic             gen_tick, last_tick, has_next, loop_ok, load_ok;

    pow2_tick_gen u_tick (
        .Clock  (Clock),
        .Clear  (Reset || state == IDLE || state == LOAD),
        .Enable (state == RUN),
        .Power  (CurPower),
        .Tick   (gen_tick)
    );

    // Stop kills the strobe in the very cycle it is raised
    assign Tick     = gen_tick && !Stop;
    assign Busy     = state != IDLE;
    assign Done     = state == DONE && !Stop;
    assign idx_inc  = idx + 1'b1;
    assign load_ok  = tbl[idx].count != '0;
    assign has_next = idx != IW'(DEPTH - 1) && tbl[idx_inc].count != '0;
    assign loop_ok  = Loop && tbl[0].count != '0;
    assign last_tick = Tick && remaining == CNT_W'(1);

    always_comb begin
        state_n = state;
        idx_n   = idx;
        case (state)
            IDLE: if (Start) begin
                state_n = LOAD;
                idx_n   = '0;
            end
            LOAD: state_n = load_ok ? RUN : DONE;
            RUN:  if (last_tick) begin
                state_n = (has_next || loop_ok) ? LOAD : DONE;
                idx_n   = has_next ? idx_inc : loop_ok ? '0 : idx;
            end
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
        if (Stop)
            state_n = IDLE;
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state     <= IDLE;
            idx       <= '0;
            remaining <= '0;
            CurIndex  <= '0;
            CurPower  <= '0;
            for (int i = 0; i < DEPTH; i++)
                tbl[i] <= '0;
        end else begin
            state <= state_n;
            idx   <= idx_n;
            if (state == IDLE && WrEn)
                tbl[WrAddr] <= '{power: WrPower, count: WrCount};
            if (state == LOAD && load_ok) begin
                CurIndex  <= idx;
                CurPower  <= tbl[idx].power;
                remaining <= tbl[idx].count;
            end else if (Tick && remaining > CNT_W'(1)) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

`ifdef RATE_SEQ_TICK_COUNT_EN
    always_ff @(posedge Clock) begin
        if (Reset || (state == IDLE && Start && !Stop))
            TickTotal <= '0;
        else if (Tick && TickTotal != 16'hFFFF)
            TickTotal <= TickTotal + 16'd1;
    end
`endif

endmodule
